i2s_tx_serializer: RTL and testbench

Transmit end of the sample path. Takes the 16-bit signed samples produced by the voice sources, such as the oneshot drum voices, and serializes them onto the codec playback pins in standard I2S format. It derives `bclk` and `pblrc` from `mclk` (256× sample rate) and latches one stereo pair per frame. A `sample_ack` pulse tells upstream when the next pair may be presented.

---
 rtl/i2s_tx_serializer_pkg.sv | 16 +
 rtl/i2s_tx_serializer_if.sv | 25 ++
 rtl/i2s_tx_serializer_frame_counter.sv | 78 +++++++
 rtl/i2s_tx_serializer.sv | 71 +++++++
 tb/tb_i2s_tx_serializer.sv | 124 ++++++++++++
 5 files changed

// File: rtl/i2s_tx_serializer_pkg.sv
// Shared types and frame geometry for the I2S transmit serializer.
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } i2s_state_t;

  localparam int FRAME_MCLKS   = 256;
  localparam int SLOT_BCLKS    = 32;
  localparam int MCLK_PER_BCLK = 4;

  localparam logic [7:0] CNT_LAST = 8'(FRAME_MCLKS - 1);

endpackage

// File: rtl/i2s_tx_serializer_if.sv
// Upstream sample handshake plus codec playback pins of the I2S transmitter.
interface i2s_tx_serializer_if #(
  parameter int SAMPLE_BITS = 16
) ();

  logic                          en;
  logic signed [SAMPLE_BITS-1:0] left_in;
  logic signed [SAMPLE_BITS-1:0] right_in;
  logic                          sample_ack;
  logic                          bclk;
  logic                          pblrc;
  logic                          pbdat;
  logic                          busy;

  modport master (
    output en, left_in, right_in,
    input  sample_ack, bclk, pblrc, pbdat, busy
  );

  modport slave (
    input  en, left_in, right_in,
    output sample_ack, bclk, pblrc, pbdat, busy
  );

endinterface

// File: rtl/i2s_tx_serializer_frame_counter.sv
// Frame counter and IDLE/RUN/DRAIN sequencer; produces the capture strobe,
// the registered sample_ack/busy, and the next-state count for the output mux.
module i2s_frame_counter
  import i2s_pkg::*;
(
  input  logic       mclk,
  input  logic       rst_n,
  input  logic       en_i,
  output logic [7:0] cnt_d_o,
  output logic       capture_o,
  output logic       sample_ack_o,
  output logic       busy_o
);

  i2s_state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       capture;
  logic       busy_d;
  logic       ack_q;
  logic       busy_q;

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= capture;
      busy_q  <= busy_d;
    end
  end

  // A capture always lands the counter on 0, so ack_q is high exactly at cnt==0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 8'd1;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (en_i) begin
          state_d = RUN;
          capture = 1'b1;
        end
      end
      RUN: begin
        if (!en_i) begin
          state_d = DRAIN;
        end else if (cnt_q == CNT_LAST) begin
          capture = 1'b1;
        end
      end
      DRAIN: begin
        if (en_i) begin
          state_d = RUN;
          capture = (cnt_q == CNT_LAST);
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  assign cnt_d_o      = cnt_d;
  assign capture_o    = capture;
  assign sample_ack_o = ack_q;
  assign busy_o       = busy_q;

endmodule

// File: rtl/i2s_tx_serializer.sv
// I2S transmit serializer: latches a stereo pair per frame and shifts it out
// MSB first with a one-bclk delay; all pins registered from the next count.
module i2s_tx_serializer
  import i2s_pkg::*;
#(
  parameter int SAMPLE_BITS = 16
) (
  input  logic                 mclk,
  input  logic                 rst_n,
  i2s_tx_serializer_if.slave   bus
);

  localparam int BCLK_BIT = $clog2(MCLK_PER_BCLK) - 1;

  logic [7:0]                    cnt_d;
  logic                          capture;
  logic                          sample_ack;
  logic                          busy;
  logic signed [SAMPLE_BITS-1:0] left_q, left_d;
  logic signed [SAMPLE_BITS-1:0] right_q, right_d;
  logic [4:0]                    slot_d;
  logic [SLOT_BCLKS-1:0]         word_d;
  logic                          bclk_q, bclk_d;
  logic                          pblrc_q, pblrc_d;
  logic                          pbdat_q, pbdat_d;

  i2s_frame_counter u_cnt (
    .mclk         (mclk),
    .rst_n        (rst_n),
    .en_i         (bus.en),
    .cnt_d_o      (cnt_d),
    .capture_o    (capture),
    .sample_ack_o (sample_ack),
    .busy_o       (busy)
  );

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      left_q  <= '0;
      right_q <= '0;
      bclk_q  <= 1'b0;
      pblrc_q <= 1'b0;
      pbdat_q <= 1'b0;
    end else begin
      left_q  <= left_d;
      right_q <= right_d;
      bclk_q  <= bclk_d;
      pblrc_q <= pblrc_d;
      pbdat_q <= pbdat_d;
    end
  end

  // The sample sits at bits 30..31-SAMPLE_BITS of a 32-bit slot word with bit 31
  // forced to 0, so slot k maps to word bit 31-k (~k): slot 0 and the tail read 0.
  always_comb begin
    left_d  = capture ? bus.left_in  : left_q;
    right_d = capture ? bus.right_in : right_q;
    slot_d  = cnt_d[6:2];
    bclk_d  = cnt_d[BCLK_BIT];
    pblrc_d = cnt_d[7];
    word_d  = SLOT_BCLKS'({1'b0, (cnt_d[7] ? right_d : left_d)}) << (SLOT_BCLKS - 1 - SAMPLE_BITS);
    pbdat_d = word_d[~slot_d];
  end

  assign bus.sample_ack = sample_ack;
  assign bus.busy       = busy;
  assign bus.bclk       = bclk_q;
  assign bus.pblrc      = pblrc_q;
  assign bus.pbdat      = pbdat_q;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench for i2s_tx_serializer: frame timing, data mapping, drain,
// re-arm without gap, and asynchronous mid-frame reset.
module tb_i2s_tx_serializer;

  logic mclk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  i2s_tx_serializer_if #(.SAMPLE_BITS(16)) bus ();

  i2s_tx_serializer #(.SAMPLE_BITS(16)) dut (
    .mclk  (mclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0b expected %0b", tag, got, exp);
    end
  endtask

  // I2S reference: slot k (1..16) carries bit 16-k of the channel word.
  function automatic logic exp_pbdat(input int cn, input logic [15:0] l, input logic [15:0] r);
    int          k;
    logic [15:0] s;
    logic [3:0]  idx;
    k   = (cn >> 2) & 31;
    s   = ((cn & 128) != 0) ? r : l;
    idx = 4'(16 - k);
    if (k >= 1 && k <= 16) return s[idx];
    return 1'b0;
  endfunction

  task automatic cyc(input int cn, input logic [15:0] l, input logic [15:0] r,
                     input logic busy_e, input logic ack_e);
    logic [7:0] c;
    c = 8'(cn);
    @(posedge mclk);
    #1;
    chk($sformatf("ack@%0d", cn),   bus.sample_ack, ack_e);
    chk($sformatf("busy@%0d", cn),  bus.busy,       busy_e);
    chk($sformatf("bclk@%0d", cn),  bus.bclk,       c[1]);
    chk($sformatf("pblrc@%0d", cn), bus.pblrc,      c[7]);
    chk($sformatf("pbdat@%0d", cn), bus.pbdat,      exp_pbdat(cn, l, r));
  endtask

  task automatic outs_zero(input string tag);
    chk({tag, "_ack"},   bus.sample_ack, 1'b0);
    chk({tag, "_busy"},  bus.busy,       1'b0);
    chk({tag, "_bclk"},  bus.bclk,       1'b0);
    chk({tag, "_pblrc"}, bus.pblrc,      1'b0);
    chk({tag, "_pbdat"}, bus.pbdat,      1'b0);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.en       = 1'b1;
    bus.left_in  = 16'hA5A5;
    bus.right_in = 16'h0001;

    repeat (3) @(posedge mclk);
    #1;
    outs_zero("reset");
    rst_n = 1'b1;

    // Frame 0: A5A5 / 0001; queue 8000 for the next capture.
    for (int i = 0; i < 256; i++) begin
      cyc(i, 16'hA5A5, 16'h0001, 1'b1, i == 0);
      if (i == 200) bus.left_in = 16'h8000;
    end

    // Frame 1: mid-frame input change must not leak into the current frame.
    for (int i = 0; i < 256; i++) begin
      cyc(i, 16'h8000, 16'h0001, 1'b1, i == 0);
      if (i == 10) bus.left_in = 16'h7FFF;
    end

    // Frame 2: drop en at cnt 40; frame completes, then IDLE.
    for (int i = 0; i < 256; i++) begin
      cyc(i, 16'h7FFF, 16'h0001, 1'b1, i == 0);
      if (i == 40)  bus.en = 1'b0;
      if (i == 100) bus.left_in = 16'h1111;
    end
    for (int i = 0; i < 3; i++) cyc(0, 16'h0000, 16'h0000, 1'b0, 1'b0);

    bus.left_in  = 16'h1234;
    bus.right_in = 16'hFEDC;
    bus.en       = 1'b1;

    // Frame 3: drain from cnt 40, re-armed during cnt 255 -> capture without gap.
    for (int i = 0; i < 256; i++) begin
      cyc(i, 16'h1234, 16'hFEDC, 1'b1, i == 0);
      if (i == 40)  bus.en = 1'b0;
      if (i == 100) bus.left_in = 16'h0F0F;
      if (i == 255) bus.en = 1'b1;
    end

    // Frame 4: async reset in the right channel at cnt 150.
    for (int i = 0; i <= 150; i++) cyc(i, 16'h0F0F, 16'hFEDC, 1'b1, i == 0);
    rst_n        = 1'b0;
    bus.left_in  = 16'h00FF;
    bus.right_in = 16'h8001;
    #1;
    outs_zero("async_rst");
    @(posedge mclk);
    #1;
    outs_zero("held_rst");
    rst_n = 1'b1;

    // Restart from cnt 0 after reset release.
    for (int i = 0; i < 48; i++) cyc(i, 16'h00FF, 16'h8001, 1'b1, i == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
